disp_sched: RTL and testbench
=============================

DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter DWELL_W, default 26, width of the dwell count.
REQ-002 Parameter DWELL_RST, default 50_000_000, dwell value in use when `dwell` input is all-zero and reset-only override is not applied (see REQ-016).
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low (0 = reset).
REQ-005 EN  in  1  global enable; 0 freezes the scheduler.
REQ-006 mode_auto  in  1  1 = auto-cycle through sources, 0 = manual select.
REQ-007 sw_sel  in  3  manual source index (SW[7:5]).
REQ-008 hold  in  1  level; pauses auto-cycling.
REQ-009 step  in  1  single-cycle pulse; advance one eligible source while in HOLD.
REQ-010 src_mask  in  8  bit i = 1 makes Disp source i eligible for auto-cycling.
REQ-011 dwell  in  DWELL_W  cycles each source is shown in AUTO.
REQ-012 Disp_sel  out  3  registered select driving the display mux.
REQ-013 sel_valid  out  1  registered; 1 when src_mask != 0.
REQ-014 sel_chg  out  1  registered one-cycle pulse in the cycle after Disp_sel changes value.
REQ-015 state  out  2  FSM state: IDLE=0, MANUAL=1, AUTO=2, HOLD=3.

Function
REQ-016 Effective dwell D = dwell if dwell != 0, else DWELL_RST; D = 1 advances every cycle.
REQ-017 Next-eligible search: lowest index strictly after Disp_sel, wrapping 7 -> 0; if only current is eligible, Disp_sel unchanged; if src_mask = 0, Disp_sel unchanged, no sel_chg.
REQ-018 Transition priority: EN=0 > mode_auto > hold; evaluated each cycle.
REQ-019 Any state, EN=0 -> IDLE next cycle; Disp_sel, dwell counter held.
REQ-020 IDLE, EN=1 -> AUTO if mode_auto=1, else MANUAL.
REQ-021 MANUAL: Disp_sel <= sw_sel every cycle (1-cycle latency), mask ignored; mode_auto=1 -> AUTO with counter cleared to 0.
REQ-022 AUTO: counter increments each cycle; when counter = D-1, Disp_sel <= next eligible and counter <= 0.
REQ-023 AUTO: if current Disp_sel is not eligible and src_mask != 0, advance to next eligible on the next edge regardless of counter, counter <= 0.
REQ-024 AUTO: hold=1 -> HOLD, counter value retained; mode_auto=0 -> MANUAL.
REQ-025 HOLD: counter frozen; step=1 advances to next eligible and clears counter; hold=0 -> AUTO, counting resumes from retained value; mode_auto=0 -> MANUAL.
REQ-026 step ignored in IDLE, MANUAL, AUTO; simultaneous step and leaving HOLD: transition taken, step ignored.
REQ-027 Counter saturating compare uses >= D-1 so a reduced dwell mid-count advances next cycle, never waits for wrap.
REQ-028 sel_chg asserted exactly once per Disp_sel change, including manual changes.

Reset
REQ-029 rst=0 asynchronously forces state=IDLE, Disp_sel=0, counter=0, sel_chg=0, sel_valid=0.
REQ-030 Reset mid-count discards the count; after release, first active edge evaluates REQ-020.

Configuration
REQ-031 Macro DISP_SCHED_STEP_EN: when defined, step behaves per REQ-025; when undefined, step port remains but is ignored and HOLD only freezes.

Verification
REQ-032 rst released, EN=1, mode_auto=1, src_mask=8'hFF, dwell=4 -> Disp_sel 0,1,2,... changing every 4 cycles, 7 wraps to 0, sel_chg pulse each change.
REQ-033 src_mask=8'b1010_0100, dwell=2, Disp_sel=2 -> sequence 2,5,7,2; clear bit 5 while showing 5 -> advance to 7 next edge.
REQ-034 mode_auto=0, sw_sel=3'd6 -> Disp_sel=6 one cycle later, state=1; mask=0 -> sel_valid=0, Disp_sel still 6.
REQ-035 AUTO counter at 2 of dwell=5, hold=1, two step pulses (macro defined) -> two advances, counter 0; hold=0 -> next advance after 5 cycles; macro undefined -> no advance.
REQ-036 EN=0 mid-count -> state=0, Disp_sel frozen; rst=0 asynchronously mid-cycle -> Disp_sel=0, state=0 without a clock edge.

Source files
------------

// File: rtl/disp_sched_if.sv
// Display scheduler bus: control inputs and registered select outputs.
// The master side drives the controls, the slave side (disp_sched) returns the select.
interface disp_sched_if #(
    parameter int DWELL_W = 26
);
    logic               EN;
    logic               mode_auto;
    logic [2:0]         sw_sel;
    logic               hold;
    logic               step;
    logic [7:0]         src_mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         Disp_sel;
    logic               sel_valid;
    logic               sel_chg;
    logic [1:0]         state;

    modport master (
        output EN, mode_auto, sw_sel, hold, step, src_mask, dwell,
        input  Disp_sel, sel_valid, sel_chg, state
    );

    modport slave (
        input  EN, mode_auto, sw_sel, hold, step, src_mask, dwell,
        output Disp_sel, sel_valid, sel_chg, state
    );
endinterface

// File: rtl/disp_sched.sv
// Display source scheduler: manual select or timed auto-cycling over eligible sources.
// Optional macro DISP_SCHED_STEP_EN enables single-step advance while in HOLD.
module disp_sched #(
    parameter int DWELL_W   = 26,
    parameter int DWELL_RST = 50_000_000
) (
    input logic          clk,
    input logic          rst,
    disp_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_DEF = DWELL_W'(DWELL_RST);

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               chg_q, valid_q;
    logic [DWELL_W-1:0] dwell_m1;
    logic [2:0]         sel_nxt;
    logic               cur_inelig;
    logic               step_ok;

    // First eligible source strictly after cur, wrapping; cur itself if none other.
    function automatic logic [2:0] next_elig(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] res;
        logic [2:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < 8; k++) begin
            idx = cur + 3'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

`ifdef DISP_SCHED_STEP_EN
    assign step_ok = bus.step;
`else
    assign step_ok = 1'b0 & bus.step;
`endif

    assign dwell_m1   = ((bus.dwell != '0) ? bus.dwell : DWELL_DEF) - DWELL_W'(1);
    assign sel_nxt    = next_elig(sel_q, bus.src_mask);
    assign cur_inelig = (bus.src_mask != 8'h00) && !bus.src_mask[sel_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!bus.EN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, MANUAL: state_d = bus.mode_auto ? AUTO : MANUAL;
                AUTO: begin
                    if (!bus.mode_auto) state_d = MANUAL;
                    else if (bus.hold)  state_d = HOLD;
                end
                HOLD: begin
                    if (!bus.mode_auto) state_d = MANUAL;
                    else if (!bus.hold) state_d = AUTO;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A state transition out of AUTO/HOLD takes priority over counting or stepping.
    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q;
        if (bus.EN) begin
            case (state_q)
                MANUAL: begin
                    sel_d = bus.sw_sel;
                    if (bus.mode_auto) cnt_d = '0;
                end
                AUTO: begin
                    if (bus.mode_auto && !bus.hold) begin
                        if (cur_inelig || (cnt_q >= dwell_m1)) begin
                            sel_d = sel_nxt;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + DWELL_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.mode_auto && bus.hold && step_ok) begin
                        sel_d = sel_nxt;
                        cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            chg_q   <= (sel_d != sel_q);
            valid_q <= (bus.src_mask != 8'h00);
        end
    end

    assign bus.Disp_sel  = sel_q;
    assign bus.sel_valid = valid_q;
    assign bus.sel_chg   = chg_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural scheduler model.
module tb_disp_sched;
    localparam int DW   = 8;
    localparam int DRST = 20;
`ifdef DISP_SCHED_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif
    localparam int S_IDLE = 0, S_MAN = 1, S_AUTO = 2, S_HOLD = 3;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    int m_state, m_sel, m_cnt;
    bit m_chg, m_valid;

    disp_sched_if #(.DWELL_W(DW)) bus ();
    disp_sched #(.DWELL_W(DW), .DWELL_RST(DRST)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic int next_src(input int cur, input logic [7:0] mask);
        int elig[$];
        for (int i = 0; i < 8; i++) if (mask[i]) elig.push_back(i);
        if (elig.size() == 0) return cur;
        for (int j = 0; j < elig.size(); j++) if (elig[j] > cur) return elig[j];
        return elig[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_sel = 0; m_cnt = 0; m_chg = 0; m_valid = 0;
    endtask

    task automatic model_edge();
        int prev, d;
        prev = m_sel;
        d = (bus.dwell != 0) ? int'(bus.dwell) : DRST;
        if (!bus.EN) begin
            m_state = S_IDLE;
        end else if (m_state == S_IDLE) begin
            m_state = bus.mode_auto ? S_AUTO : S_MAN;
        end else if (m_state == S_MAN) begin
            m_sel = int'(bus.sw_sel);
            if (bus.mode_auto) begin m_state = S_AUTO; m_cnt = 0; end
        end else if (m_state == S_AUTO) begin
            if (!bus.mode_auto) m_state = S_MAN;
            else if (bus.hold) m_state = S_HOLD;
            else if ((bus.src_mask != 0 && !bus.src_mask[m_sel]) || m_cnt >= d - 1) begin
                m_sel = next_src(m_sel, bus.src_mask);
                m_cnt = 0;
            end else m_cnt++;
        end else begin
            if (!bus.mode_auto) m_state = S_MAN;
            else if (!bus.hold) m_state = S_AUTO;
            else if (bus.step && STEP_EN) begin
                m_sel = next_src(m_sel, bus.src_mask);
                m_cnt = 0;
            end
        end
        m_chg   = (m_sel != prev);
        m_valid = (bus.src_mask != 0);
    endtask

    task automatic check_all();
        chk("sel",   32'(bus.Disp_sel),  32'(m_sel));
        chk("state", 32'(bus.state),     32'(m_state));
        chk("chg",   32'(bus.sel_chg),   32'(m_chg));
        chk("valid", 32'(bus.sel_valid), 32'(m_valid));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int n;
        bit found;
        rst = 1'b1;
        bus.EN = 1'b0; bus.mode_auto = 1'b1; bus.sw_sel = 3'd0; bus.hold = 1'b0;
        bus.step = 1'b0; bus.src_mask = 8'hFF; bus.dwell = DW'(4);
        model_reset();
        #2;
        rst_pulse();

        // auto-cycle over all sources, dwell 4
        bus.EN = 1'b1;
        cyc();
        chk("q32_state", 32'(bus.state), 32'd2);
        for (int k = 1; k <= 8; k++) begin
            repeat (4) cyc();
            chk("q32_sel", 32'(bus.Disp_sel), 32'(k % 8));
            chk("q32_chg", 32'(bus.sel_chg), 32'd1);
        end

        // sparse mask, then eligibility removed under the current source
        rst_pulse();
        bus.src_mask = 8'b1010_0100; bus.dwell = DW'(2);
        cyc(); cyc();
        chk("q33_sel2", 32'(bus.Disp_sel), 32'd2);
        repeat (2) cyc(); chk("q33_sel5", 32'(bus.Disp_sel), 32'd5);
        repeat (2) cyc(); chk("q33_sel7", 32'(bus.Disp_sel), 32'd7);
        repeat (2) cyc(); chk("q33_wrap", 32'(bus.Disp_sel), 32'd2);
        repeat (2) cyc(); chk("q33_at5", 32'(bus.Disp_sel), 32'd5);
        bus.src_mask = 8'b1000_0100;
        cyc();
        chk("q33_skip", 32'(bus.Disp_sel), 32'd7);

        // manual selection and empty mask
        rst_pulse();
        bus.mode_auto = 1'b0; bus.sw_sel = 3'd6;
        cyc(); chk("q34_state", 32'(bus.state), 32'd1);
        cyc(); chk("q34_sel", 32'(bus.Disp_sel), 32'd6);
        chk("q34_chg", 32'(bus.sel_chg), 32'd1);
        bus.src_mask = 8'h00;
        cyc(); chk("q34_valid", 32'(bus.sel_valid), 32'd0);
        chk("q34_keep", 32'(bus.Disp_sel), 32'd6);
        bus.sw_sel = 3'd3;
        cyc(); chk("q34_sel3", 32'(bus.Disp_sel), 32'd3);
        chk("q34_chg3", 32'(bus.sel_chg), 32'd1);

        // hold with step pulses
        rst_pulse();
        bus.mode_auto = 1'b1; bus.src_mask = 8'hFF; bus.dwell = DW'(5);
        repeat (3) cyc();
        bus.hold = 1'b1;
        cyc(); chk("q35_hold", 32'(bus.state), 32'd3);
        bus.step = 1'b1; cyc(); bus.step = 1'b0; cyc();
        bus.step = 1'b1; cyc(); bus.step = 1'b0; cyc();
        chk("q35_steps", 32'(bus.Disp_sel), STEP_EN ? 32'd2 : 32'd0);
        bus.hold = 1'b0;
        n = 0; found = 1'b0;
        for (int i = 1; i <= 10 && !found; i++) begin
            cyc();
            if (bus.sel_chg === 1'b1) begin n = i; found = 1'b1; end
        end
        chk("q35_gap", 32'(n), STEP_EN ? 32'd6 : 32'd4);

        // enable dropped mid-count, then asynchronous reset between edges
        repeat (2) cyc();
        bus.EN = 1'b0;
        cyc(); chk("q36_idle", 32'(bus.state), 32'd0);
        repeat (3) cyc();
        chk("q36_frozen", 32'(bus.Disp_sel), STEP_EN ? 32'd3 : 32'd1);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("q36_async_sel", 32'(bus.Disp_sel), 32'd0);
        chk("q36_async_state", 32'(bus.state), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // randomized traffic against the model
        bus.EN = 1'b1;
        for (int it = 0; it < 1500; it++) begin
            bus.EN        = ($urandom_range(0, 19) != 0);
            bus.mode_auto = ($urandom_range(0, 9) != 0);
            bus.hold      = ($urandom_range(0, 6) == 0);
            bus.step      = ($urandom_range(0, 2) == 0);
            bus.sw_sel    = 3'($urandom);
            if ($urandom_range(0, 9) == 0) bus.src_mask = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.dwell = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) rst_pulse();
            else cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
